// File: rtl/reg_bank_sb.sv
// 32 x 32-bit register bank with a per-register pending-write scoreboard.
// Register contents are driven in parallel to the read muxes; the scoreboard flags RAW/WAW hazards.
module reg_bank_sb #(
  parameter bit          ZERO_REG  = 1'b1,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic        iss_valid,
  input  logic        iss_wr,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  rs_a,
  input  logic [4:0]  rs_b,
  output logic [31:0] q00, q01, q02, q03, q04, q05, q06, q07,
  output logic [31:0] q08, q09, q10, q11, q12, q13, q14, q15,
  output logic [31:0] q16, q17, q18, q19, q20, q21, q22, q23,
  output logic [31:0] q24, q25, q26, q27, q28, q29, q30, q31,
  output logic [31:0] pend,
  output logic        busy_a,
  output logic        busy_b,
  output logic        stall,
  output logic [5:0]  pend_cnt
);

  logic [31:0] rf [32];
  logic [31:0] pend_reg;
  logic [31:0] pend_next;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;
  logic [5:0]  pend_cnt_reg;
  logic [5:0]  pend_cnt_next;
  logic        issue_fire;

  assign busy_a     = pend_reg[rs_a];
  assign busy_b     = pend_reg[rs_b];
  assign stall      = iss_valid & (busy_a | busy_b | (iss_wr & pend_reg[iss_rd]));
  assign issue_fire = iss_valid & ~stall;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_reg
      if (gi == 0 && ZERO_REG) begin : g_zero
        // Hardwired zero: no storage, never claimed by an issuing instruction.
        assign rf[gi]      = 32'h0000_0000;
        assign set_vec[gi] = 1'b0;
        assign clr_vec[gi] = 1'b0;
      end else begin : g_flop
        logic [31:0] r_reg;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)
            r_reg <= RESET_VAL;
          else if (we && (wa == 5'(gi)))
            r_reg <= wd;
        end
        assign rf[gi]      = r_reg;
        assign set_vec[gi] = issue_fire & iss_wr & (iss_rd == 5'(gi));
        assign clr_vec[gi] = we & (wa == 5'(gi));
      end
    end
  endgenerate

  // Set has priority: a new producer claims the register in the same cycle the old one retires.
  assign pend_next = (pend_reg & ~clr_vec) | set_vec;

  always_comb begin
    pend_cnt_next = 6'd0;
    for (int i = 0; i < 32; i++)
      pend_cnt_next = pend_cnt_next + {5'd0, pend_next[i]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg     <= 32'h0000_0000;
      pend_cnt_reg <= 6'd0;
    end else begin
      pend_reg     <= pend_next;
      pend_cnt_reg <= pend_cnt_next;
    end
  end

  assign pend     = pend_reg;
  assign pend_cnt = pend_cnt_reg;

  assign q00 = rf[0];  assign q01 = rf[1];  assign q02 = rf[2];  assign q03 = rf[3];
  assign q04 = rf[4];  assign q05 = rf[5];  assign q06 = rf[6];  assign q07 = rf[7];
  assign q08 = rf[8];  assign q09 = rf[9];  assign q10 = rf[10]; assign q11 = rf[11];
  assign q12 = rf[12]; assign q13 = rf[13]; assign q14 = rf[14]; assign q15 = rf[15];
  assign q16 = rf[16]; assign q17 = rf[17]; assign q18 = rf[18]; assign q19 = rf[19];
  assign q20 = rf[20]; assign q21 = rf[21]; assign q22 = rf[22]; assign q23 = rf[23];
  assign q24 = rf[24]; assign q25 = rf[25]; assign q26 = rf[26]; assign q27 = rf[27];
  assign q28 = rf[28]; assign q29 = rf[29]; assign q30 = rf[30]; assign q31 = rf[31];

endmodule

// File: doc/reg_bank_sb.md
Name: reg_bank_sb

Overview:
- 32-entry x 32-bit processor register bank with a per-register pending-write scoreboard.
- Sits directly upstream of the register read multiplexers. Drives all 32 register contents in parallel as q00..q31. The muxes select from these using the rs fields.
- Takes write-back from the final pipeline stage.
- Tracks destinations of issued-but-not-retired instructions so the issue stage can stall on RAW/WAW hazards.

Parameters:
- ZERO_REG, 1, when 1 register 0 is hardwired to zero: writes ignored, never marked pending. When 0, register 0 behaves like any other register.
- RESET_VAL, 32'h0000_0000, value loaded into every register on reset.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- we  input  1  write-back enable
- wa  input  5  write-back register address
- wd  input  32  write-back data
- iss_valid  input  1  issue stage presents an instruction this cycle
- iss_wr  input  1  issuing instruction writes a destination register
- iss_rd  input  5  issuing instruction destination register
- rs_a  input  5  issuing instruction source A
- rs_b  input  5  issuing instruction source B
- q00..q31  output  32 each  registered contents of registers 0..31, to read muxes
- pend  output  32  scoreboard vector, bit n = register n has an outstanding write
- busy_a  output  1  source A pending
- busy_b  output  1  source B pending
- stall  output  1  issue must hold this cycle
- pend_cnt  output  6  number of set bits in pend (0..32)

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. While rst_n=0:
  - q00..q31 = RESET_VAL (q00 = 0 if ZERO_REG=1).
  - pend = 0, pend_cnt = 0.
  - busy_a, busy_b and stall follow their combinational equations from pend=0.
- Reset asserted mid-operation discards all pending state and register contents immediately. No write completes in the cycle reset deasserts unless rst_n is high at the clock edge.
- Write:
  - On a rising edge with we=1, q[wa] <= wd.
  - With ZERO_REG=1 and wa=0, the write is dropped.
  - Latency one clock: new value visible on q[wa] after the edge. No same-cycle write-through to q.
- busy_a = pend[rs_a]; busy_b = pend[rs_b]. Both are combinational.
  - With ZERO_REG=1, rs=0 gives busy=0.
  - A write-back in the current cycle does not clear busy until the following cycle. Data reaches q only then.
- stall = iss_valid & (busy_a | busy_b | (iss_wr & pend[iss_rd])). The last term is the WAW check. stall is combinational.
- issue_fire = iss_valid & ~stall.
- Scoreboard update per edge for each bit n:
  - Set when issue_fire & iss_wr & iss_rd==n (and not n==0 with ZERO_REG=1).
  - Clear when we & wa==n.
  - Set and clear on the same n in the same cycle: set wins, so the bit stays 1 because a new producer is claiming the register.
  - A write-back to a register with pend=0 is legal: data written, pend unchanged.
- pend_cnt:
  - Registered alongside pend.
  - Equals popcount of the next pend value.
  - +1 / -1 / 0 per cycle from the rules above; never wraps. 32 is reachable only with ZERO_REG=0.
- No internal FSM beyond the scoreboard bits. Outputs q are pure flops with no combinational path from inputs.

Test Plan:
- Reset then write: rst_n low 2 cycles, then we=1 wa=5 wd=32'hDEADBEEF for 1 cycle -> q05=DEADBEEF one edge later; all other q stay 0; pend=0.
- Zero register: we=1 wa=0 wd=32'hFFFFFFFF; iss_valid=1 iss_wr=1 iss_rd=0 (ZERO_REG=1) -> q00 stays 0, pend[0]=0, stall=0, pend_cnt=0.
- RAW stall:
  - Issue iss_rd=7 -> pend[7]=1, pend_cnt=1.
  - Next cycle issue rs_a=7 -> busy_a=1, stall=1, no pend change.
  - Write-back we=1 wa=7 wd=32'h12345678 -> next cycle pend[7]=0, busy_a=0, stall=0, q07=12345678.
- WAW: pend[9]=1, iss_valid=1 iss_wr=1 iss_rd=9 rs_a=rs_b=0 -> stall=1, pend_cnt unchanged.
- Simultaneous set/clear: pend[3]=1; same cycle we=1 wa=3 and an issue with iss_rd=3 -> reaches the scoreboard only if not stalled, so preload pend[3]=0 with a stray write-back to 3 plus issue to 3 -> pend[3]=1 after edge, pend_cnt +1. Also with pend[4]=1: we wa=4 plus issue iss_rd=6 -> pend[4]=0, pend[6]=1, pend_cnt unchanged.
- Async reset mid-run: pend=32'h0000_00F0 and q10=32'hA5A5A5A5; drop rst_n between clock edges -> pend, pend_cnt and all q are 0 immediately, before the next edge.
